// File: rtl/sdrpi_net_cfg_pkg.sv
// sdrpi_net_cfg_pkg: states, record layout and validation for the net cfg loader.
// WR0/WR1 exist only when NETCFG_WRITEBACK_EN is defined.
package sdrpi_net_cfg_pkg;

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_RD0,
    S_RD1,
    S_CHECK,
    S_READY
`ifdef NETCFG_WRITEBACK_EN
    ,
    S_WR0,
    S_WR1
`endif
  } state_t;

  localparam int W0_MAGIC_LSB = 48;
  localparam int W0_IP_LSB    = 16;
  localparam int W0_PA_LSB    = 0;
  localparam int W1_MAC_LSB   = 16;
  localparam int W1_PB_LSB    = 0;
  localparam int MAC_MCAST    = 40;

  localparam logic [15:0] DEF_MAGIC = 16'hC0DE;

  function automatic logic cfg_rec_valid(
    input logic [15:0] magic,
    input logic [15:0] exp_magic,
    input logic [31:0] ip,
    input logic [47:0] mac,
    input logic [15:0] pa,
    input logic [15:0] pb
  );
    return (magic == exp_magic)
        && (ip != 32'h0)
        && (ip != 32'hFFFF_FFFF)
        && !mac[MAC_MCAST]
        && (mac != 48'h0)
        && (pa != 16'h0)
        && (pb != 16'h0);
  endfunction

  function automatic logic [63:0] rec_word0(
    input logic [15:0] magic,
    input logic [31:0] ip,
    input logic [15:0] pa
  );
    return {magic, ip, pa};
  endfunction

  function automatic logic [63:0] rec_word1(
    input logic [47:0] mac,
    input logic [15:0] pb
  );
    return {mac, pb};
  endfunction

endpackage

// File: rtl/sdrpi_net_cfg_loader.sv
// sdrpi_net_cfg_loader: boot-time EEPROM network config loader with defaults.
// Optional EEPROM write-back path under NETCFG_WRITEBACK_EN.
module sdrpi_net_cfg_loader
  import sdrpi_net_cfg_pkg::*;
#(
  parameter logic [31:0] DEF_IP      = 32'hC0A8_0380,
  parameter logic [47:0] DEF_MAC     = 48'h0002_0000_0000,
  parameter logic [15:0] DEF_PORT_A  = 16'd8080,
  parameter logic [15:0] DEF_PORT_B  = 16'd8090,
  parameter logic [7:0]  CFG_BASE    = 8'h00,
  parameter logic [15:0] MAGIC       = DEF_MAGIC,
  parameter int          TIMEOUT_CYC = 2_500_000
) (
  input  logic        clk_125m,
  input  logic        rst_n,
  input  logic        eeprom_idle,
  output logic        rd_req,
  output logic [7:0]  rd_addr,
  input  logic [63:0] rd_u64,
  input  logic        rd_done,
  input  logic        reload,
  output logic [31:0] cfg_my_ip,
  output logic [47:0] cfg_my_mac,
  output logic [15:0] cfg_port_a,
  output logic [15:0] cfg_port_b,
  output logic        cfg_valid,
  output logic        cfg_from_eeprom,
  output logic        cfg_err
`ifdef NETCFG_WRITEBACK_EN
  ,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [63:0] wr_u64,
  input  logic        wr_done,
  input  logic        save_req,
  input  logic [31:0] save_ip,
  input  logic [47:0] save_mac,
  input  logic [15:0] save_port_a,
  input  logic [15:0] save_port_b,
  output logic        save_busy,
  output logic        save_err
`endif
);

  localparam logic [21:0] TO_LIM = 22'(TIMEOUT_CYC);

  state_t      r_state;
  state_t      w_next;
  logic [21:0] r_cnt;
  logic        r_done_q;
  logic [63:0] r_w0;
  logic [63:0] r_w1;
  logic [31:0] r_ip;
  logic [47:0] r_mac;
  logic [15:0] r_pa;
  logic [15:0] r_pb;
  logic        r_valid;
  logic        r_from;
  logic        r_err;
  logic        w_to;
  logic        w_rd_ack;
  logic        w_rd_to;
  logic        w_rec_ok;
  logic        w_xfer_ack;

  assign w_to     = (r_cnt >= TO_LIM);
  assign w_rd_ack = rd_done & rd_req;
  assign w_rd_to  = (r_state inside {S_WAIT_IDLE, S_RD0, S_RD1})
                 && (w_next == S_READY);
  assign w_rec_ok = cfg_rec_valid(
    r_w0[W0_MAGIC_LSB +: 16], MAGIC,
    r_w0[W0_IP_LSB +: 32], r_w1[W1_MAC_LSB +: 48],
    r_w0[W0_PA_LSB +: 16], r_w1[W1_PB_LSB +: 16]);

`ifdef NETCFG_WRITEBACK_EN
  logic [31:0] r_s_ip;
  logic [47:0] r_s_mac;
  logic [15:0] r_s_pa;
  logic [15:0] r_s_pb;
  logic        r_busy;
  logic        r_save_err;
  logic        r_err_pulse;
  logic        w_wr_ack;
  logic        w_save_ok;
  logic        w_save_take;
  logic        w_wr_to;

  assign w_wr_ack    = wr_done & wr_req;
  assign w_save_ok   = cfg_rec_valid(MAGIC, MAGIC, save_ip, save_mac,
                                     save_port_a, save_port_b);
  assign w_save_take = (r_state == S_READY) && save_req && !reload;
  assign w_wr_to     = (r_state inside {S_WR0, S_WR1}) && !w_wr_ack
                    && (w_next == S_READY);
  assign w_xfer_ack  = w_rd_ack | w_wr_ack;
  assign save_busy   = r_busy;
  assign save_err    = r_save_err;
`else
  assign w_xfer_ack  = w_rd_ack;
`endif

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_WAIT_IDLE: if (eeprom_idle) w_next = S_RD0;
                   else if (w_to)   w_next = S_READY;
      S_RD0:       if (w_rd_ack)    w_next = S_RD1;
                   else if (w_to)   w_next = S_READY;
      S_RD1:       if (w_rd_ack)    w_next = S_CHECK;
                   else if (w_to)   w_next = S_READY;
      S_CHECK:     w_next = S_READY;
      S_READY:     if (reload)      w_next = S_WAIT_IDLE;
`ifdef NETCFG_WRITEBACK_EN
                   else if (save_req && w_save_ok) w_next = S_WR0;
      S_WR0:       if (w_wr_ack)    w_next = S_WR1;
                   else if (w_to)   w_next = S_READY;
      S_WR1:       if (w_wr_ack || w_to) w_next = S_READY;
`endif
      default:     w_next = S_WAIT_IDLE;
    endcase
  end

  // Request is withheld for one cycle after each completion.
  always_comb begin
    rd_req  = (r_state inside {S_RD0, S_RD1}) && !r_done_q;
    rd_addr = (r_state == S_RD1) ? CFG_BASE + 8'd8 : CFG_BASE;
`ifdef NETCFG_WRITEBACK_EN
    wr_req  = (r_state inside {S_WR0, S_WR1}) && !r_done_q;
    wr_addr = (r_state == S_WR1) ? CFG_BASE + 8'd8 : CFG_BASE;
    wr_u64  = (r_state == S_WR1) ? rec_word1(r_s_mac, r_s_pb)
                                 : rec_word0(MAGIC, r_s_ip, r_s_pa);
`endif
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_done_q <= 1'b0;
    end else begin
      r_done_q <= w_xfer_ack;
      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != '1)  r_cnt <= r_cnt + 22'd1;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      r_w0    <= '0;
      r_w1    <= '0;
      r_ip    <= DEF_IP;
      r_mac   <= DEF_MAC;
      r_pa    <= DEF_PORT_A;
      r_pb    <= DEF_PORT_B;
      r_valid <= 1'b0;
      r_from  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_RD0 && w_rd_ack) r_w0 <= rd_u64;
      if (r_state == S_RD1 && w_rd_ack) r_w1 <= rd_u64;
      if (r_state == S_READY && reload) r_valid <= 1'b0;
      if (r_state == S_CHECK && w_rec_ok) begin
        r_ip    <= r_w0[W0_IP_LSB +: 32];
        r_mac   <= r_w1[W1_MAC_LSB +: 48];
        r_pa    <= r_w0[W0_PA_LSB +: 16];
        r_pb    <= r_w1[W1_PB_LSB +: 16];
        r_valid <= 1'b1;
        r_from  <= 1'b1;
        r_err   <= 1'b0;
      end
      if ((r_state == S_CHECK && !w_rec_ok) || w_rd_to) begin
        r_ip    <= DEF_IP;
        r_mac   <= DEF_MAC;
        r_pa    <= DEF_PORT_A;
        r_pb    <= DEF_PORT_B;
        r_valid <= 1'b1;
        r_from  <= 1'b0;
        r_err   <= 1'b1;
      end
`ifdef NETCFG_WRITEBACK_EN
      if (r_state == S_WR1 && w_wr_ack) begin
        r_ip   <= r_s_ip;
        r_mac  <= r_s_mac;
        r_pa   <= r_s_pa;
        r_pb   <= r_s_pb;
        r_from <= 1'b1;
      end
`endif
    end
  end

`ifdef NETCFG_WRITEBACK_EN
  // Invalid-value error is a one-cycle pulse; timeout error is sticky.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      r_s_ip      <= '0;
      r_s_mac     <= '0;
      r_s_pa      <= '0;
      r_s_pb      <= '0;
      r_busy      <= 1'b0;
      r_save_err  <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      if (w_save_take) begin
        r_save_err  <= !w_save_ok;
        r_err_pulse <= !w_save_ok;
        if (w_save_ok) begin
          r_s_ip  <= save_ip;
          r_s_mac <= save_mac;
          r_s_pa  <= save_port_a;
          r_s_pb  <= save_port_b;
          r_busy  <= 1'b1;
        end
      end else if (r_err_pulse) begin
        r_save_err  <= 1'b0;
        r_err_pulse <= 1'b0;
      end
      if (r_state == S_WR1 && w_wr_ack) r_busy <= 1'b0;
      if (w_wr_to) begin
        r_busy     <= 1'b0;
        r_save_err <= 1'b1;
      end
    end
  end
`endif

  assign cfg_my_ip       = r_ip;
  assign cfg_my_mac      = r_mac;
  assign cfg_port_a      = r_pa;
  assign cfg_port_b      = r_pb;
  assign cfg_valid       = r_valid;
  assign cfg_from_eeprom = r_from;
  assign cfg_err         = r_err;

endmodule
